// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and occupancy-width helper shared by the param_fifo slice
package fifo_pkg;
  localparam int MODE_REG  = 0;
  localparam int MODE_FWFT = 1;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W register array, one write port (we/waddr/wdata), one async read port (raddr/rdata), no reset
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/param_fifo.sv
// param_fifo: synchronous FIFO (clk/rstn/clr; wr_en/wr_data in; rd_en/rd_data/rd_valid out; registered full/empty/almost/count/sticky overflow+underflow)
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = MODE_REG
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      fifo_full,
  output logic                      fifo_empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] AF = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE = CW'(AE_LEVEL);
  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4 || DEPTH > 256 || AE_LEVEL >= AF_LEVEL || DATA_W < 1 || DATA_W > 64) begin : g_bad_param
    $fatal(1, "param_fifo: illegal DEPTH/AE_LEVEL/AF_LEVEL/DATA_W");
  end
  logic [PW-1:0]     wr_ptr, rd_ptr, wp_nxt, rp_nxt;
  logic [CW-1:0]     cnt_nxt;
  logic [DATA_W-1:0] head, rd_q;
  logic              rd_v_q, wr_acc, rd_acc;
  always_comb begin
    rd_acc  = rd_en & ~fifo_empty;
    wr_acc  = wr_en & (~fifo_full | rd_acc);
    wp_nxt  = clr ? '0 : wr_ptr + PW'(wr_acc);
    rp_nxt  = clr ? '0 : rd_ptr + PW'(rd_acc);
    cnt_nxt = clr ? '0 : count + CW'(wr_acc) - CW'(rd_acc);
  end
  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (wr_acc & ~clr),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(head)
  );
  // full/empty come from the wrap-bit pointer compare of the next state, so they are registered alongside count
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_v_q       <= 1'b0;
      rd_q         <= '0;
    end else begin
      wr_ptr       <= wp_nxt;
      rd_ptr       <= rp_nxt;
      count        <= cnt_nxt;
      fifo_full    <= wp_nxt == {~rp_nxt[AW], rp_nxt[AW-1:0]};
      fifo_empty   <= wp_nxt == rp_nxt;
      almost_full  <= cnt_nxt >= AF;
      almost_empty <= cnt_nxt <= AE;
      overflow     <= ~clr & (overflow | (wr_en & ~wr_acc));
      underflow    <= ~clr & (underflow | (rd_en & fifo_empty));
      rd_v_q       <= ~clr & rd_acc;
      if (!clr && rd_acc) rd_q <= head;
    end
  assign rd_data  = (FWFT == MODE_FWFT) ? (fifo_empty ? '0 : head) : rd_q;
  assign rd_valid = (FWFT == MODE_FWFT) ? ~fifo_empty : rd_v_q;
endmodule
